// File: rtl/tpu_cfg_bridge.sv
// Control/config bridge between a host controller and the systolic MLP core.
// Forwards weight/activation traffic with one cycle of latency, keeps a
// shadow/active pair of normalisation and quantisation settings, sequences
// each run, enforces a watchdog on it, and snapshots the accumulators.
module tpu_cfg_bridge #(
  parameter int N_COLS    = 2,
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 32,
  parameter int IDLE_CODE = 0,
  parameter int DONE_CODE = 7,
  parameter int TIMEOUT   = 1023,
  parameter int CW        = $clog2(N_COLS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ctrl_wf_push,
  input  logic [CW-1:0]            ctrl_wf_col,
  input  logic [DATA_W-1:0]        ctrl_wf_data,
  input  logic                     ctrl_wf_reset,
  input  logic                     ctrl_init_act_valid,
  input  logic [N_COLS*DATA_W-1:0] ctrl_init_act_data,
  input  logic                     ctrl_weights_ready,
  input  logic                     ctrl_start_mlp,
  input  logic                     cfg_wr_en,
  input  logic [2:0]               cfg_addr,
  input  logic [31:0]              cfg_wdata,
  input  logic [CW-1:0]            ctrl_acc_sel,
  output logic                     ctrl_busy,
  output logic                     ctrl_acc_valid,
  output logic [ACC_W-1:0]         ctrl_acc,
  output logic                     ctrl_err,
  output logic [2:0]               mlp_state,
  output logic [4:0]               mlp_cycle_cnt,
  output logic [N_COLS-1:0]        mlp_wf_push,
  output logic [DATA_W-1:0]        mlp_wf_data_in,
  output logic                     mlp_wf_reset,
  output logic                     mlp_init_act_valid,
  output logic [N_COLS*DATA_W-1:0] mlp_init_act_data,
  output logic                     mlp_weights_ready,
  output logic                     mlp_start_mlp,
  output logic [15:0]              mlp_norm_gain,
  output logic [31:0]              mlp_norm_bias,
  output logic [4:0]               mlp_norm_shift,
  output logic [15:0]              mlp_q_inv_scale,
  output logic [7:0]               mlp_q_zero_point,
  input  logic [3:0]               mlp_state_in,
  input  logic [4:0]               mlp_cycle_cnt_in,
  input  logic [N_COLS*ACC_W-1:0]  mlp_acc_in
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  localparam logic [15:0] DEF_GAIN  = 16'd256;
  localparam logic [31:0] DEF_BIAS  = 32'd0;
  localparam logic [4:0]  DEF_SHIFT = 5'd8;
  localparam logic [15:0] DEF_INV   = 16'd256;
  localparam logic [7:0]  DEF_ZP    = 8'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMMIT,
    S_START,
    S_RUN,
    S_CAPTURE,
    S_DRAIN
  } state_t;

  state_t             state_q;
  logic [WD_W-1:0]    wd_q;
  logic               start_q;
  logic               acc_valid_q;
  logic               err_q;
  logic               err_d;
  logic [ACC_W-1:0]   snap_q [N_COLS];

  // Shadow (host-visible) and active (core-visible) configuration sets
  logic [15:0] sh_gain_q, act_gain_q;
  logic [31:0] sh_bias_q, act_bias_q;
  logic [4:0]  sh_shift_q, act_shift_q;
  logic [15:0] sh_inv_q, act_inv_q;
  logic [7:0]  sh_zp_q, act_zp_q;

  // Forwarded traffic, registered once
  logic [N_COLS-1:0]        push_d;
  logic [N_COLS-1:0]        push_q;
  logic [DATA_W-1:0]        wf_data_q;
  logic                     wf_reset_q;
  logic                     act_valid_q;
  logic [N_COLS*DATA_W-1:0] act_data_q;
  logic                     wready_q;
  logic [2:0]               st_q;
  logic [4:0]               cyc_cnt_q;

  logic col_ok;
  logic is_done;
  logic is_idle_code;
  logic wd_expired;
  logic err_set;
  logic err_clr;

  // One-hot push decode; an out-of-range column never matches any bit
  for (genvar gi = 0; gi < N_COLS; gi++) begin : g_push
    assign push_d[gi] = ctrl_wf_push && (int'(ctrl_wf_col) == gi);
  end

  // Error sources and the sticky-flag next state (set wins over clear)
  always_comb begin
    col_ok       = int'(ctrl_wf_col) < N_COLS;
    is_done      = mlp_state_in == 4'(DONE_CODE);
    is_idle_code = mlp_state_in == 4'(IDLE_CODE);
    wd_expired   = wd_q == WD_W'(TIMEOUT - 1);
    err_set      = 1'b0;
    if (ctrl_wf_push && !col_ok) err_set = 1'b1;
    if (cfg_wr_en && cfg_addr[2:1] == 2'b11) err_set = 1'b1;
    if (ctrl_start_mlp && state_q == S_IDLE && !ctrl_weights_ready) err_set = 1'b1;
    if (ctrl_start_mlp && state_q != S_IDLE) err_set = 1'b1;
    if (state_q == S_RUN && !is_done && wd_expired) err_set = 1'b1;
    err_clr = cfg_wr_en && cfg_addr == 3'd5 && cfg_wdata[1];
    err_d   = err_set | (err_q & ~err_clr);
  end

  // Host writes land only in the shadow set; command bit0 restores defaults
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_gain_q  <= DEF_GAIN;
      sh_bias_q  <= DEF_BIAS;
      sh_shift_q <= DEF_SHIFT;
      sh_inv_q   <= DEF_INV;
      sh_zp_q    <= DEF_ZP;
    end else if (cfg_wr_en) begin
      case (cfg_addr)
        3'd0: sh_gain_q  <= cfg_wdata[15:0];
        3'd1: sh_bias_q  <= cfg_wdata;
        3'd2: sh_shift_q <= cfg_wdata[4:0];
        3'd3: sh_inv_q   <= cfg_wdata[15:0];
        3'd4: sh_zp_q    <= cfg_wdata[7:0];
        3'd5: begin
          if (cfg_wdata[0]) begin
            sh_gain_q  <= DEF_GAIN;
            sh_bias_q  <= DEF_BIAS;
            sh_shift_q <= DEF_SHIFT;
            sh_inv_q   <= DEF_INV;
            sh_zp_q    <= DEF_ZP;
          end
        end
        default: ;
      endcase
    end
  end

  // Weight/activation/status forwarding with a fixed one-cycle delay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_q      <= '0;
      wf_data_q   <= '0;
      wf_reset_q  <= 1'b0;
      act_valid_q <= 1'b0;
      act_data_q  <= '0;
      wready_q    <= 1'b0;
      st_q        <= '0;
      cyc_cnt_q   <= '0;
    end else begin
      push_q      <= push_d;
      wf_data_q   <= ctrl_wf_data;
      wf_reset_q  <= ctrl_wf_reset;
      act_valid_q <= ctrl_init_act_valid;
      act_data_q  <= ctrl_init_act_data;
      wready_q    <= ctrl_weights_ready;
      st_q        <= mlp_state_in[2:0];
      cyc_cnt_q   <= mlp_cycle_cnt_in;
    end
  end

  // Run sequencer: commit config, pulse start, watch for done/timeout, snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wd_q        <= '0;
      start_q     <= 1'b0;
      acc_valid_q <= 1'b0;
      err_q       <= 1'b0;
      act_gain_q  <= DEF_GAIN;
      act_bias_q  <= DEF_BIAS;
      act_shift_q <= DEF_SHIFT;
      act_inv_q   <= DEF_INV;
      act_zp_q    <= DEF_ZP;
      for (int c = 0; c < N_COLS; c++) snap_q[c] <= '0;
    end else begin
      err_q   <= err_d;
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ctrl_start_mlp && ctrl_weights_ready) state_q <= S_COMMIT;
        end
        S_COMMIT: begin
          // Uses the shadow value registered before this cycle, so a write
          // arriving now only takes effect on the next run.
          act_gain_q  <= sh_gain_q;
          act_bias_q  <= sh_bias_q;
          act_shift_q <= sh_shift_q;
          act_inv_q   <= sh_inv_q;
          act_zp_q    <= sh_zp_q;
          acc_valid_q <= 1'b0;
          start_q     <= 1'b1;
          state_q     <= S_START;
        end
        S_START: begin
          wd_q    <= '0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (is_done) begin
            state_q <= S_CAPTURE;
          end else if (wd_expired) begin
            state_q <= S_IDLE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_CAPTURE: begin
          for (int c = 0; c < N_COLS; c++) snap_q[c] <= mlp_acc_in[c*ACC_W +: ACC_W];
          acc_valid_q <= 1'b1;
          state_q     <= S_DRAIN;
        end
        S_DRAIN: begin
          if (is_idle_code) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Snapshot readback; out-of-range selects read as zero
  always_comb begin
    ctrl_acc = '0;
    if (int'(ctrl_acc_sel) < N_COLS) ctrl_acc = snap_q[ctrl_acc_sel];
  end

  assign ctrl_busy          = state_q != S_IDLE;
  assign ctrl_acc_valid     = acc_valid_q;
  assign ctrl_err           = err_q;
  assign mlp_state          = st_q;
  assign mlp_cycle_cnt      = cyc_cnt_q;
  assign mlp_wf_push        = push_q;
  assign mlp_wf_data_in     = wf_data_q;
  assign mlp_wf_reset       = wf_reset_q;
  assign mlp_init_act_valid = act_valid_q;
  assign mlp_init_act_data  = act_data_q;
  assign mlp_weights_ready  = wready_q;
  assign mlp_start_mlp      = start_q;
  assign mlp_norm_gain      = act_gain_q;
  assign mlp_norm_bias      = act_bias_q;
  assign mlp_norm_shift     = act_shift_q;
  assign mlp_q_inv_scale    = act_inv_q;
  assign mlp_q_zero_point   = act_zp_q;

endmodule

// File: tb/tb_tpu_cfg_bridge.sv
// Scoreboard bench for tpu_cfg_bridge: stimulus queues expected events,
// a monitor pops and compares them as the DUT produces them.
module tb_tpu_cfg_bridge;

  localparam int N_COLS = 2;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int TO     = 15;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     ctrl_wf_push;
  logic [0:0]               ctrl_wf_col;
  logic [DATA_W-1:0]        ctrl_wf_data;
  logic                     ctrl_wf_reset;
  logic                     ctrl_init_act_valid;
  logic [N_COLS*DATA_W-1:0] ctrl_init_act_data;
  logic                     ctrl_weights_ready;
  logic                     ctrl_start_mlp;
  logic                     cfg_wr_en;
  logic [2:0]               cfg_addr;
  logic [31:0]              cfg_wdata;
  logic [0:0]               ctrl_acc_sel = 1'b0;
  logic                     ctrl_busy;
  logic                     ctrl_acc_valid;
  logic [ACC_W-1:0]         ctrl_acc;
  logic                     ctrl_err;
  logic [2:0]               mlp_state;
  logic [4:0]               mlp_cycle_cnt;
  logic [N_COLS-1:0]        mlp_wf_push;
  logic [DATA_W-1:0]        mlp_wf_data_in;
  logic                     mlp_wf_reset;
  logic                     mlp_init_act_valid;
  logic [N_COLS*DATA_W-1:0] mlp_init_act_data;
  logic                     mlp_weights_ready;
  logic                     mlp_start_mlp;
  logic [15:0]              mlp_norm_gain;
  logic [31:0]              mlp_norm_bias;
  logic [4:0]               mlp_norm_shift;
  logic [15:0]              mlp_q_inv_scale;
  logic [7:0]               mlp_q_zero_point;
  logic [3:0]               mlp_state_in;
  logic [4:0]               mlp_cycle_cnt_in;
  logic [N_COLS*ACC_W-1:0]  mlp_acc_in;

  tpu_cfg_bridge #(.N_COLS(N_COLS), .DATA_W(DATA_W), .ACC_W(ACC_W),
                   .IDLE_CODE(0), .DONE_CODE(7), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ctrl_wf_push(ctrl_wf_push), .ctrl_wf_col(ctrl_wf_col), .ctrl_wf_data(ctrl_wf_data),
    .ctrl_wf_reset(ctrl_wf_reset), .ctrl_init_act_valid(ctrl_init_act_valid),
    .ctrl_init_act_data(ctrl_init_act_data), .ctrl_weights_ready(ctrl_weights_ready),
    .ctrl_start_mlp(ctrl_start_mlp), .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .ctrl_acc_sel(ctrl_acc_sel), .ctrl_busy(ctrl_busy),
    .ctrl_acc_valid(ctrl_acc_valid), .ctrl_acc(ctrl_acc), .ctrl_err(ctrl_err),
    .mlp_state(mlp_state), .mlp_cycle_cnt(mlp_cycle_cnt), .mlp_wf_push(mlp_wf_push),
    .mlp_wf_data_in(mlp_wf_data_in), .mlp_wf_reset(mlp_wf_reset),
    .mlp_init_act_valid(mlp_init_act_valid), .mlp_init_act_data(mlp_init_act_data),
    .mlp_weights_ready(mlp_weights_ready), .mlp_start_mlp(mlp_start_mlp),
    .mlp_norm_gain(mlp_norm_gain), .mlp_norm_bias(mlp_norm_bias),
    .mlp_norm_shift(mlp_norm_shift), .mlp_q_inv_scale(mlp_q_inv_scale),
    .mlp_q_zero_point(mlp_q_zero_point), .mlp_state_in(mlp_state_in),
    .mlp_cycle_cnt_in(mlp_cycle_cnt_in), .mlp_acc_in(mlp_acc_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic [15:0] gain; logic [31:0] bias; logic [4:0] shift;
                   logic [15:0] inv; logic [7:0] zp; int cyc; } start_exp_t;
  typedef struct { logic [1:0] push; logic [7:0] data; int cyc; } wf_exp_t;
  typedef struct { logic v; logic [31:0] a0; logic [31:0] a1; int cyc; } accv_exp_t;
  typedef struct { logic v; int cyc; } err_exp_t;
  typedef struct { logic v; logic [15:0] gain; int cyc; } busy_exp_t;

  start_exp_t q_start[$];
  wf_exp_t    q_wf[$];
  accv_exp_t  q_accv[$];
  err_exp_t   q_err[$];
  busy_exp_t  q_busy[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_cyc(input string name, input int act, input int exp);
    if (exp >= 0) begin
      n_cmp++;
      if (act != exp) begin
        n_bad++;
        $display("FAIL %s_cycle: got %0d, expected %0d", name, act, exp);
      end
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got an event at cycle %0d, expected none", name, cyc);
  endtask

  task automatic exp_start(input logic [15:0] g, input logic [31:0] b, input logic [4:0] s,
                           input logic [15:0] iv, input logic [7:0] z, input int c);
    start_exp_t e;
    e.gain = g; e.bias = b; e.shift = s; e.inv = iv; e.zp = z; e.cyc = c;
    q_start.push_back(e);
  endtask

  task automatic exp_wf(input logic [1:0] p, input logic [7:0] d, input int c);
    wf_exp_t e;
    e.push = p; e.data = d; e.cyc = c;
    q_wf.push_back(e);
  endtask

  task automatic exp_accv(input logic v, input logic [31:0] a0, input logic [31:0] a1, input int c);
    accv_exp_t e;
    e.v = v; e.a0 = a0; e.a1 = a1; e.cyc = c;
    q_accv.push_back(e);
  endtask

  task automatic exp_err(input logic v, input int c);
    err_exp_t e;
    e.v = v; e.cyc = c;
    q_err.push_back(e);
  endtask

  task automatic exp_busy(input logic v, input logic [15:0] g, input int c);
    busy_exp_t e;
    e.v = v; e.gain = g; e.cyc = c;
    q_busy.push_back(e);
  endtask

  // Monitor: compares every DUT output event against the queued expectation
  logic prev_start = 1'b0, prev_busy = 1'b0, prev_err = 1'b0, prev_accv = 1'b0;
  start_exp_t m_s;
  wf_exp_t    m_w;
  accv_exp_t  m_a;
  err_exp_t   m_e;
  busy_exp_t  m_b;

  always begin
    @(negedge clk);
    if (rst_n) begin
      if (mlp_wf_push != '0) begin
        if (q_wf.size() == 0) unexpected("wf_push");
        else begin
          m_w = q_wf.pop_front();
          $display("[%0d] wf push=%b data=0x%0h", cyc, mlp_wf_push, mlp_wf_data_in);
          chk("wf_push", 64'(mlp_wf_push), 64'(m_w.push));
          chk("wf_data", 64'(mlp_wf_data_in), 64'(m_w.data));
          chk_cyc("wf", cyc, m_w.cyc);
        end
      end
      if (mlp_start_mlp) begin
        if (prev_start) unexpected("start_width");
        else if (q_start.size() == 0) unexpected("start_pulse");
        else begin
          m_s = q_start.pop_front();
          $display("[%0d] start gain=%0d bias=0x%0h shift=%0d inv=0x%0h zp=0x%0h", cyc,
                   mlp_norm_gain, mlp_norm_bias, mlp_norm_shift, mlp_q_inv_scale, mlp_q_zero_point);
          chk("start_gain", 64'(mlp_norm_gain), 64'(m_s.gain));
          chk("start_bias", 64'(mlp_norm_bias), 64'(m_s.bias));
          chk("start_shift", 64'(mlp_norm_shift), 64'(m_s.shift));
          chk("start_inv", 64'(mlp_q_inv_scale), 64'(m_s.inv));
          chk("start_zp", 64'(mlp_q_zero_point), 64'(m_s.zp));
          chk_cyc("start", cyc, m_s.cyc);
        end
      end
      if (ctrl_busy !== prev_busy) begin
        if (q_busy.size() == 0) unexpected("busy_change");
        else begin
          m_b = q_busy.pop_front();
          $display("[%0d] busy=%b gain=%0d", cyc, ctrl_busy, mlp_norm_gain);
          chk("busy", 64'(ctrl_busy), 64'(m_b.v));
          chk("busy_gain", 64'(mlp_norm_gain), 64'(m_b.gain));
          chk_cyc("busy", cyc, m_b.cyc);
        end
      end
      if (ctrl_err !== prev_err) begin
        if (q_err.size() == 0) unexpected("err_change");
        else begin
          m_e = q_err.pop_front();
          $display("[%0d] err=%b", cyc, ctrl_err);
          chk("err", 64'(ctrl_err), 64'(m_e.v));
          chk_cyc("err", cyc, m_e.cyc);
        end
      end
      if (ctrl_acc_valid !== prev_accv) begin
        if (q_accv.size() == 0) unexpected("acc_valid_change");
        else begin
          m_a = q_accv.pop_front();
          $display("[%0d] acc_valid=%b", cyc, ctrl_acc_valid);
          chk("acc_valid", 64'(ctrl_acc_valid), 64'(m_a.v));
          chk_cyc("acc_valid", cyc, m_a.cyc);
          if (ctrl_acc_valid) begin
            ctrl_acc_sel = 1'b0;
            #1;
            chk("acc_sel0", 64'(ctrl_acc), 64'(m_a.a0));
            ctrl_acc_sel = 1'b1;
            #1;
            chk("acc_sel1", 64'(ctrl_acc), 64'(m_a.a1));
            ctrl_acc_sel = 1'b0;
          end
        end
      end
    end
    prev_start = mlp_start_mlp;
    prev_busy  = ctrl_busy;
    prev_err   = ctrl_err;
    prev_accv  = ctrl_acc_valid;
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
    cfg_wr_en = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_wr_en = 1'b0;
  endtask

  task automatic pulse_start(input logic ready);
    ctrl_weights_ready = ready;
    ctrl_start_mlp = 1'b1;
    step();
    ctrl_start_mlp = 1'b0;
  endtask

  int k;

  initial begin
    rst_n = 1'b0;
    ctrl_wf_push = 0; ctrl_wf_col = 0; ctrl_wf_data = 0; ctrl_wf_reset = 0;
    ctrl_init_act_valid = 0; ctrl_init_act_data = 0; ctrl_weights_ready = 0;
    ctrl_start_mlp = 0; cfg_wr_en = 0; cfg_addr = 0; cfg_wdata = 0;
    mlp_state_in = 0; mlp_cycle_cnt_in = 0; mlp_acc_in = '0;
    step(3);
    rst_n = 1'b1;
    step(2);

    // Reset state
    chk("rst_gain", 64'(mlp_norm_gain), 64'd256);
    chk("rst_shift", 64'(mlp_norm_shift), 64'd8);
    chk("rst_inv", 64'(mlp_q_inv_scale), 64'd256);
    chk("rst_bias", 64'(mlp_norm_bias), 64'd0);
    chk("rst_zp", 64'(mlp_q_zero_point), 64'd0);
    chk("rst_busy", 64'(ctrl_busy), 64'd0);
    chk("rst_err", 64'(ctrl_err), 64'd0);
    chk("rst_acc_valid", 64'(ctrl_acc_valid), 64'd0);
    chk("rst_acc", 64'(ctrl_acc), 64'd0);

    // Weight pushes to column 1 then column 0
    ctrl_wf_push = 1; ctrl_wf_col = 1; ctrl_wf_data = 8'hA5;
    exp_wf(2'b10, 8'hA5, cyc + 1);
    step();
    ctrl_wf_col = 0; ctrl_wf_data = 8'h3C;
    exp_wf(2'b01, 8'h3C, cyc + 1);
    step();
    ctrl_wf_push = 0;
    ctrl_init_act_valid = 1; ctrl_init_act_data = 16'hBEEF;
    step();
    chk("act_valid_fwd", 64'(mlp_init_act_valid), 64'd1);
    chk("act_data_fwd", 64'(mlp_init_act_data), 64'hBEEF);
    ctrl_init_act_valid = 0;
    step(2);

    // Run 1: gain written to shadow, committed at run start; DONE with {-5,300}
    cfg_write(3'd0, 32'd512);
    step();
    chk("shadow_not_active", 64'(mlp_norm_gain), 64'd256);
    mlp_state_in = 4'd7;
    mlp_acc_in = {32'd300, 32'hFFFF_FFFB};
    k = cyc;
    exp_busy(1'b1, 16'd256, k + 1);
    exp_start(16'd512, 32'd0, 5'd8, 16'd256, 8'd0, k + 2);
    exp_accv(1'b1, 32'hFFFF_FFFB, 32'd300, k + 5);
    exp_busy(1'b0, 16'd512, -1);
    pulse_start(1'b1);
    step(6);
    mlp_state_in = 4'd0;
    step(3);

    // Start without weights ready: refused, error set; then cleared
    k = cyc;
    exp_err(1'b1, k + 1);
    pulse_start(1'b0);
    step(2);
    chk("noready_err", 64'(ctrl_err), 64'd1);
    exp_err(1'b0, cyc + 1);
    cfg_write(3'd5, 32'd2);
    step(2);

    // Run 2: core never finishes; watchdog aborts after TO run cycles
    mlp_state_in = 4'd3;
    k = cyc;
    exp_busy(1'b1, 16'd512, k + 1);
    exp_accv(1'b0, 32'd0, 32'd0, k + 2);
    exp_start(16'd512, 32'd0, 5'd8, 16'd256, 8'd0, k + 2);
    exp_err(1'b1, k + 3 + TO);
    exp_busy(1'b0, 16'd512, k + 3 + TO);
    pulse_start(1'b1);
    step(TO + 6);
    chk("to_err", 64'(ctrl_err), 64'd1);
    chk("to_busy", 64'(ctrl_busy), 64'd0);
    chk("to_acc_valid", 64'(ctrl_acc_valid), 64'd0);

    // Defaults + clear, then field writes, illegal addresses, set/clear collision
    exp_err(1'b0, cyc + 1);
    cfg_write(3'd5, 32'd3);
    cfg_write(3'd2, 32'hFFFF_FFE5);
    cfg_write(3'd3, 32'h0000_1234);
    cfg_write(3'd4, 32'h0000_0180);
    exp_err(1'b1, cyc + 1);
    cfg_write(3'd6, 32'hFFFF_FFFF);
    cfg_write(3'd7, 32'hFFFF_FFFF);
    exp_err(1'b0, cyc + 1);
    cfg_write(3'd5, 32'd2);
    exp_err(1'b1, cyc + 1);
    ctrl_weights_ready = 0; ctrl_start_mlp = 1;
    cfg_wr_en = 1; cfg_addr = 3'd5; cfg_wdata = 32'd2;
    step();
    ctrl_start_mlp = 0; cfg_wr_en = 0;
    step();
    exp_err(1'b0, cyc + 1);
    cfg_write(3'd5, 32'd2);
    step();

    // Run 3: bias write during commit is deferred; second start is rejected
    mlp_state_in = 4'd3;
    mlp_acc_in = {32'hFFFF_FFFF, 32'd1000};
    k = cyc;
    exp_busy(1'b1, 16'd512, k + 1);
    exp_start(16'd256, 32'd0, 5'd5, 16'h1234, 8'h80, k + 2);
    exp_err(1'b1, k + 6);
    exp_accv(1'b1, 32'd1000, 32'hFFFF_FFFF, k + 10);
    exp_busy(1'b0, 16'd256, -1);
    pulse_start(1'b1);
    cfg_write(3'd1, 32'h1234_5678);
    step(3);
    ctrl_start_mlp = 1;
    step();
    ctrl_start_mlp = 0;
    step(2);
    mlp_state_in = 4'd7;
    step(4);
    mlp_state_in = 4'd0;
    step(3);
    exp_err(1'b0, cyc + 1);
    cfg_write(3'd5, 32'd2);
    step();

    // Run 4: deferred bias now active; snapshot replaced
    mlp_state_in = 4'd7;
    mlp_acc_in = {32'hFFFF_FFF9, 32'd7};
    k = cyc;
    exp_busy(1'b1, 16'd256, k + 1);
    exp_accv(1'b0, 32'd0, 32'd0, k + 2);
    exp_start(16'd256, 32'h1234_5678, 5'd5, 16'h1234, 8'h80, k + 2);
    exp_accv(1'b1, 32'd7, 32'hFFFF_FFF9, k + 5);
    exp_busy(1'b0, 16'd256, -1);
    pulse_start(1'b1);
    step(6);
    mlp_state_in = 4'd0;
    step(5);

    chk("end_err", 64'(ctrl_err), 64'd0);
    chk("end_busy", 64'(ctrl_busy), 64'd0);
    chk("end_acc_valid", 64'(ctrl_acc_valid), 64'd1);
    chk("left_start", 64'(q_start.size()), 64'd0);
    chk("left_wf", 64'(q_wf.size()), 64'd0);
    chk("left_accv", 64'(q_accv.size()), 64'd0);
    chk("left_err", 64'(q_err.size()), 64'd0);
    chk("left_busy", 64'(q_busy.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
